// File: rtl/thumb_hw_aligner.sv
// Thumb halfword aligner: buffers fetched halfwords in a 4-entry queue and
// presents complete 16/32-bit instructions with their byte address.
module thumb_hw_aligner #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       hw_in,
    input  logic              hw_valid,
    output logic              hw_ready,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_addr,
    output logic [31:0]       inst,
    output logic              inst_valid,
    output logic              inst_is32,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              dec_ready
);

    logic [15:0]       mem_q [4];
    logic [15:0]       mem_d [4];
    logic [1:0]        rd_ptr_q, rd_ptr_d;
    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [2:0]        count_q, count_d;
    logic [ADDR_W-1:0] head_addr_q, head_addr_d;
    logic [31:0]       inst_q, inst_d;
    logic              inst_valid_q, inst_valid_d;
    logic              inst_is32_q, inst_is32_d;
    logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;

    logic [15:0] head_hw;
    logic [15:0] next_hw;
    logic        head_is32;
    logic        head_complete;
    logic        load;
    logic        push;
    logic [2:0]  pop_n;

    assign hw_ready = (count_q < 3'd4);

    always_comb begin
        head_hw       = mem_q[rd_ptr_q];
        next_hw       = mem_q[rd_ptr_q + 2'd1];
        head_is32     = (head_hw[15:11] == 5'b11101) ||
                        (head_hw[15:11] == 5'b11110) ||
                        (head_hw[15:11] == 5'b11111);
        head_complete = head_is32 ? (count_q >= 3'd2) : (count_q >= 3'd1);
        load          = head_complete && (!inst_valid_q || dec_ready);
        // A halfword offered during a flush is discarded, not queued.
        push          = hw_valid && hw_ready && !flush;
        pop_n         = load ? (head_is32 ? 3'd2 : 3'd1) : 3'd0;

        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q + pop_n[1:0];
        count_d      = count_q + {2'b00, push} - pop_n;
        head_addr_d  = head_addr_q + ADDR_W'({pop_n, 1'b0});
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        inst_is32_d  = inst_is32_q;
        inst_addr_d  = inst_addr_q;

        if (push) begin
            mem_d[wr_ptr_q] = hw_in;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end

        if (load) begin
            inst_d       = head_is32 ? {head_hw, next_hw} : {head_hw, 16'h0000};
            inst_is32_d  = head_is32;
            inst_addr_d  = head_addr_q;
            inst_valid_d = 1'b1;
        end else if (dec_ready) begin
            inst_valid_d = 1'b0;
        end

        if (flush) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            inst_valid_d = 1'b0;
            head_addr_d  = flush_addr & ~ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q        <= '{default: '0};
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            head_addr_q  <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            inst_is32_q  <= 1'b0;
            inst_addr_q  <= '0;
        end else begin
            mem_q        <= mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            head_addr_q  <= head_addr_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            inst_is32_q  <= inst_is32_d;
            inst_addr_q  <= inst_addr_d;
        end
    end

    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign inst_is32  = inst_is32_q;
    assign inst_addr  = inst_addr_q;

endmodule

// File: tb/tb_thumb_hw_aligner.sv
// Directed self-checking bench for thumb_hw_aligner.
module tb_thumb_hw_aligner;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] hw_in = '0;
    logic        hw_valid = 1'b0;
    logic        hw_ready;
    logic        flush = 1'b0;
    logic [31:0] flush_addr = '0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_is32;
    logic [31:0] inst_addr;
    logic        dec_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    thumb_hw_aligner #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .hw_in      (hw_in),
        .hw_valid   (hw_valid),
        .hw_ready   (hw_ready),
        .flush      (flush),
        .flush_addr (flush_addr),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_is32  (inst_is32),
        .inst_addr  (inst_addr),
        .dec_ready  (dec_ready)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; hw_valid = 1'b0; hw_in = '0; flush = 1'b0;
        flush_addr = '0; dec_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (hw_ready !== 1'b1) begin bad++; $display("FAIL rst_init_ready got=%b want=1", hw_ready); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_init_valid got=%b want=0", inst_valid); end
        total++; if (inst !== 32'h0) begin bad++; $display("FAIL rst_init_inst got=%h want=0", inst); end
        flush = 1'b1; flush_addr = 32'h40;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            hw_valid = 1'b1; hw_in = 16'h2100 + 16'(i);
            @(negedge clk);
        end
        hw_valid = 1'b0;
        total++; if (hw_ready !== 1'b0) begin bad++; $display("FAIL rst_full_ready got=%b want=0", hw_ready); end
        total++; if (inst_addr !== 32'h40) begin bad++; $display("FAIL rst_full_addr got=%h want=00000040", inst_addr); end
        rst = 1'b0;
        #1;
        total++; if (hw_ready !== 1'b1) begin bad++; $display("FAIL rst_async_ready got=%b want=1", hw_ready); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid got=%b want=0", inst_valid); end
        total++; if (inst !== 32'h0) begin bad++; $display("FAIL rst_async_inst got=%h want=0", inst); end
        total++; if (inst_addr !== 32'h0) begin bad++; $display("FAIL rst_async_addr got=%h want=0", inst_addr); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (hw_ready !== 1'b1) begin bad++; $display("FAIL rst_after_ready got=%b want=1", hw_ready); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_after_valid got=%b want=0", inst_valid); end
    endtask

    task automatic test_stream16();
        do_reset();
        dec_ready = 1'b1; hw_valid = 1'b1; hw_in = 16'hBF08;
        @(negedge clk);
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL s16_latency got=%b want=0", inst_valid); end
        hw_in = 16'h2001;
        @(negedge clk);
        total++; if ({inst_valid, inst_is32, inst, inst_addr} !== {2'b10, 32'hBF080000, 32'h0})
            begin bad++; $display("FAIL s16_i0 got=%b%b %h @%h want=10 bf080000 @0", inst_valid, inst_is32, inst, inst_addr); end
        hw_in = 16'h2102;
        @(negedge clk);
        total++; if ({inst_valid, inst_is32, inst, inst_addr} !== {2'b10, 32'h20010000, 32'h2})
            begin bad++; $display("FAIL s16_i1 got=%b%b %h @%h want=10 20010000 @2", inst_valid, inst_is32, inst, inst_addr); end
        hw_valid = 1'b0;
        @(negedge clk);
        total++; if ({inst_valid, inst_is32, inst, inst_addr} !== {2'b10, 32'h21020000, 32'h4})
            begin bad++; $display("FAIL s16_i2 got=%b%b %h @%h want=10 21020000 @4", inst_valid, inst_is32, inst, inst_addr); end
        @(negedge clk);
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL s16_drain got=%b want=0", inst_valid); end
    endtask

    task automatic test_mixed();
        do_reset();
        dec_ready = 1'b1; hw_valid = 1'b1; hw_in = 16'hF000;
        @(negedge clk);
        hw_in = 16'hB800;
        @(negedge clk);
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL mix_prefix_wait got=%b want=0", inst_valid); end
        hw_in = 16'h4770;
        @(negedge clk);
        total++; if ({inst_valid, inst_is32, inst, inst_addr} !== {2'b11, 32'hF000B800, 32'h0})
            begin bad++; $display("FAIL mix_i32 got=%b%b %h @%h want=11 f000b800 @0", inst_valid, inst_is32, inst, inst_addr); end
        hw_valid = 1'b0;
        @(negedge clk);
        total++; if ({inst_valid, inst_is32, inst, inst_addr} !== {2'b10, 32'h47700000, 32'h4})
            begin bad++; $display("FAIL mix_i16 got=%b%b %h @%h want=10 47700000 @4", inst_valid, inst_is32, inst, inst_addr); end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int k = 0;
        logic [15:0] e;
        do_reset();
        dec_ready = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            hw_valid = (idx < 6);
            hw_in = 16'h3001 + 16'(idx);
            if (hw_valid && hw_ready) idx++;
            @(negedge clk);
        end
        hw_valid = 1'b0;
        total++; if (idx !== 5) begin bad++; $display("FAIL bp_accepted got=%0d want=5", idx); end
        total++; if (hw_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b want=0", hw_ready); end
        @(negedge clk);
        total++; if ({inst_valid, inst, inst_addr} !== {1'b1, 32'h30010000, 32'h0})
            begin bad++; $display("FAIL bp_hold got=%b %h @%h want=1 30010000 @0", inst_valid, inst, inst_addr); end
        for (int cyc = 0; cyc < 20 && k < 6; cyc++) begin
            dec_ready = 1'b1;
            hw_valid = (idx < 6);
            hw_in = 16'h3001 + 16'(idx);
            if (inst_valid) begin
                e = 16'h3001 + 16'(k);
                total++; if ({inst, inst_addr} !== {e, 16'h0000, 32'(2 * k)})
                    begin bad++; $display("FAIL bp_drain_%0d got=%h @%h want=%h0000 @%h", k, inst, inst_addr, e, 2 * k); end
                k++;
            end
            if (hw_valid && hw_ready) idx++;
            @(negedge clk);
        end
        hw_valid = 1'b0;
        total++; if (k !== 6) begin bad++; $display("FAIL bp_drain_count got=%0d want=6", k); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%b want=0", inst_valid); end
        dec_ready = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        dec_ready = 1'b1; hw_valid = 1'b1; hw_in = 16'hF7FF;
        @(negedge clk);
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL fl_orphan got=%b want=0", inst_valid); end
        hw_in = 16'hFFFE; flush = 1'b1; flush_addr = 32'h0000_0101;
        @(negedge clk);
        flush = 1'b0; hw_valid = 1'b0;
        total++; if ({inst_valid, hw_ready} !== 2'b01) begin bad++; $display("FAIL fl_state got=%b%b want=01", inst_valid, hw_ready); end
        @(negedge clk);
        hw_valid = 1'b1; hw_in = 16'h2001;
        @(negedge clk);
        hw_valid = 1'b0;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL fl_latency got=%b want=0", inst_valid); end
        @(negedge clk);
        total++; if ({inst_valid, inst_is32, inst, inst_addr} !== {2'b10, 32'h20010000, 32'h100})
            begin bad++; $display("FAIL fl_redirect got=%b%b %h @%h want=10 20010000 @100", inst_valid, inst_is32, inst, inst_addr); end
    endtask

    task automatic test_wrap();
        logic [15:0] hws [30];
        logic [31:0] exp_inst [20];
        logic        exp32 [20];
        logic [31:0] exp_addr [20];
        logic [31:0] a = 32'hFFFF_FFF0;
        int n = 0;
        int hi = 0;
        int k = 0;
        for (int i = 0; i < 20; i++) begin
            exp_addr[i] = a;
            if (i % 2 == 0) begin
                hws[n] = 16'h2000 | 16'(i);
                exp_inst[i] = {hws[n], 16'h0000};
                exp32[i] = 1'b0;
                n += 1; a += 32'd2;
            end else begin
                hws[n] = 16'hF000 | 16'(i);
                hws[n+1] = 16'h8000 | 16'(i);
                exp_inst[i] = {hws[n], hws[n+1]};
                exp32[i] = 1'b1;
                n += 2; a += 32'd4;
            end
        end
        do_reset();
        flush = 1'b1; flush_addr = 32'hFFFF_FFF1;
        @(negedge clk);
        flush = 1'b0;
        for (int cyc = 0; cyc < 300 && k < 20; cyc++) begin
            hw_valid = (hi < 30) && (cyc % 5 != 4);
            if (hi < 30) hw_in = hws[hi]; else hw_in = '0;
            dec_ready = (cyc % 4 != 3);
            total++; if (dut.count_q > 3'd4) begin bad++; $display("FAIL wr_count got=%0d want<=4", dut.count_q); end
            if (inst_valid && dec_ready) begin
                total++; if ({inst, inst_is32, inst_addr} !== {exp_inst[k], exp32[k], exp_addr[k]})
                    begin bad++; $display("FAIL wr_inst_%0d got=%h/%b @%h want=%h/%b @%h", k, inst, inst_is32, inst_addr, exp_inst[k], exp32[k], exp_addr[k]); end
                k++;
            end
            if (hw_valid && hw_ready) hi++;
            @(negedge clk);
        end
        hw_valid = 1'b0; dec_ready = 1'b0;
        total++; if (k !== 20) begin bad++; $display("FAIL wr_timeout got=%0d want=20", k); end
    endtask

    initial begin
        test_reset();
        test_stream16();
        test_mixed();
        test_backpressure();
        test_flush();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
